// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the stall/flush
// controller (slave); the perf counter outputs are always present.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_reg_d;
  logic [4:0]  ex_mem_command;
  logic        ex_redirect;
  logic        ex_halt;
  logic        mem_req;
  logic        mem_ready;
  logic        resume;
  logic        if_stop;
  logic        id_stop;
  logic        id_bubble;
  logic        ex_stop;
  logic        flush_if;
  logic        halted;
  logic [2:0]  state;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_reg_d,
           ex_mem_command, ex_redirect, ex_halt, mem_req, mem_ready, resume,
    input  if_stop, id_stop, id_bubble, ex_stop, flush_if, halted, state,
           perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_reg_d,
           ex_mem_command, ex_redirect, ex_halt, mem_req, mem_ready, resume,
    output if_stop, id_stop, id_bubble, ex_stop, flush_if, halted, state,
           perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline (Mealy outputs).
// Optional macro PIPE_HAZARD_PERF_EN adds stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LD_STALL = 3'd1,
    MEM_WAIT = 3'd2,
    FLUSH    = 3'd3,
    HALT     = 3'd4
  } state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [1:0] LD_RELOAD    = 2'((LOAD_USE_CYCLES > 1) ? LOAD_USE_CYCLES - 2 : 0);

  state_t     state_r, state_nxt_s, ret_r, ret_nxt_s;
  logic [1:0] cnt_r, cnt_nxt_s;
  logic       hz_s, mw_s;
  logic       if_stop_s, id_stop_s, id_bubble_s, ex_stop_s, flush_if_s;
  logic       if_stop_g_s, flush_if_g_s;

  assign hz_s = (bus.ex_mem_command[1:0] == 2'b01) && (bus.ex_reg_d != 5'd0) &&
                ((bus.id_uses_rs1 && (bus.id_rs1_addr == bus.ex_reg_d)) ||
                 (bus.id_uses_rs2 && (bus.id_rs2_addr == bus.ex_reg_d)));
  assign mw_s = bus.mem_req && !bus.mem_ready;

  // State, return-state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      ret_r   <= RUN;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      ret_r   <= ret_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and same-cycle stop/bubble/flush decode
  always_comb begin
    state_nxt_s = state_r;
    ret_nxt_s   = ret_r;
    cnt_nxt_s   = cnt_r;
    if_stop_s   = 1'b0;
    id_stop_s   = 1'b0;
    id_bubble_s = 1'b0;
    ex_stop_s   = 1'b0;
    flush_if_s  = 1'b0;
    case (state_r)
      RUN, LD_STALL, FLUSH: begin
        if (mw_s) begin
          if_stop_s   = 1'b1;
          id_stop_s   = 1'b1;
          ex_stop_s   = 1'b1;
          ret_nxt_s   = state_r;
          state_nxt_s = MEM_WAIT;
        end else if (bus.ex_redirect) begin
          id_bubble_s = 1'b1;
          flush_if_s  = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            state_nxt_s = FLUSH;
            cnt_nxt_s   = FLUSH_RELOAD;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (state_r == FLUSH) begin
          id_bubble_s = 1'b1;
          flush_if_s  = 1'b1;
          if (cnt_r == 2'd0) begin
            state_nxt_s = RUN;
          end else begin
            cnt_nxt_s = cnt_r - 2'd1;
          end
        end else if (state_r == LD_STALL) begin
          if_stop_s   = 1'b1;
          id_bubble_s = 1'b1;
          if (cnt_r == 2'd0) begin
            state_nxt_s = RUN;
          end else begin
            cnt_nxt_s = cnt_r - 2'd1;
          end
        end else if (bus.ex_halt) begin
          if_stop_s   = 1'b1;
          id_stop_s   = 1'b1;
          ex_stop_s   = 1'b1;
          state_nxt_s = HALT;
        end else if (hz_s) begin
          if_stop_s   = 1'b1;
          id_bubble_s = 1'b1;
          if (LOAD_USE_CYCLES > 1) begin
            state_nxt_s = LD_STALL;
            cnt_nxt_s   = LD_RELOAD;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        // Pipeline stays frozen until the access completes, then resume where we left off
        if (bus.mem_ready) begin
          state_nxt_s = ret_r;
        end else begin
          if_stop_s = 1'b1;
          id_stop_s = 1'b1;
          ex_stop_s = 1'b1;
        end
      end
      HALT: begin
        if (bus.resume) begin
          state_nxt_s = RUN;
        end else begin
          if_stop_s = 1'b1;
          id_stop_s = 1'b1;
          ex_stop_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Outputs are forced low during reset so decode performs its own reset
  assign if_stop_g_s   = if_stop_s & ~reset;
  assign flush_if_g_s  = flush_if_s & ~reset;
  assign bus.if_stop   = if_stop_g_s;
  assign bus.id_stop   = id_stop_s & ~reset;
  assign bus.id_bubble = id_bubble_s & ~reset;
  assign bus.ex_stop   = ex_stop_s & ~reset;
  assign bus.flush_if  = flush_if_g_s;
  assign bus.halted    = (state_r == HALT) && !reset;
  assign bus.state     = reset ? 3'd0 : state_r;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_r, perf_flush_r;

  // Free-running wrap-around stall and flush cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      if (if_stop_g_s && (state_r != HALT)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (flush_if_g_s) begin
        perf_flush_r <= perf_flush_r + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cnt = perf_stall_r;
  assign bus.perf_flush_cnt = perf_flush_r;
`else
  assign bus.perf_stall_cnt = 32'd0;
  assign bus.perf_flush_cnt = 32'd0;
`endif
endmodule
